vdp_port_ctrl: RTL and testbench
================================

VDP_PORT_CTRL -- requirements
Module: vdp_port_ctrl

Interface
REQ-001 SHALL have ports: pxclk in 1, pixel clock; all logic on its rising edge.
REQ-002 SHALL have reset_n in 1, reset; one clock, asynchronous, active-low.
REQ-003 SHALL have cpu_wr_stb in 1: one-pxclk pulse for a CPU write to port 0x80/0x81, already synchronized to pxclk.
REQ-004 SHALL have cpu_rd_stb in 1: one-pxclk pulse for a completed CPU read of port 0x80/0x81.
REQ-005 SHALL have cpu_port in 1: a[0]; 0 = data port 0x80, 1 = control port 0x81.
REQ-006 SHALL have cpu_wdata in 8; cpu_rdata out 8: read_buf when cpu_port=0, status_in when cpu_port=1.
REQ-007 SHALL have vid_req in 1, vid_addr in 14, vid_valid out 1: video fetch request, address, and data-valid for vram_rdata.
REQ-008 SHALL have vram_addr out 14, vram_we out 1, vram_wdata out 8, vram_rdata in 8: single-port VRAM, 1-cycle read latency.
REQ-009 SHALL have reg_we out 1, reg_num out 3, reg_data out 8: VDP register write pulse.
REQ-010 SHALL have status_in in 8; status_rd out 1: one-cycle pulse on a control-port read, clears video flags.
REQ-011 SHALL have busy out 1, a CPU VRAM op pending; overrun out 1, sticky.

Function
REQ-012 SHALL keep a 14-bit address vaddr, an 8-bit read_buf, a 1-bit latch flag and an 8-bit low-byte register lo.
REQ-013 Control write with latch=0 SHALL store cpu_wdata in lo and set latch.
REQ-014 Control write with latch=1 SHALL clear latch and decode cpu_wdata[7:6]:
- 10: reg_we=1 next cycle, reg_num=cpu_wdata[2:0], reg_data=lo.
- 01: vaddr={cpu_wdata[5:0],lo}; write setup, no VRAM access.
- 00: vaddr={cpu_wdata[5:0],lo}; queue prefetch read.
- 11: treated as 10.
REQ-015 Any data-port access or control-port read SHALL clear latch.
REQ-016 Data write SHALL queue a VRAM write of cpu_wdata at vaddr and also load read_buf with cpu_wdata.
REQ-017 Data read SHALL return the current read_buf, then queue a prefetch read at vaddr.
REQ-018 Each completed VRAM op SHALL increment vaddr modulo 2^14 (0x3FFF wraps to 0x0000).
REQ-019 FSM states SHALL be IDLE, PEND_WR, PEND_RD and RD_WAIT.
- IDLE -> PEND_WR or PEND_RD on a queued op.
- PEND_* with vid_req=1: stay in state.
- PEND_WR with vid_req=0: drive vram_we, vram_addr=vaddr -> IDLE.
- PEND_RD with vid_req=0: drive vram_addr=vaddr -> RD_WAIT.
- RD_WAIT: read_buf<=vram_rdata -> IDLE.
REQ-020 vid_req SHALL have absolute priority: when set, vram_addr=vid_addr and vram_we=0, with vid_valid=1 the following cycle.
REQ-021 busy SHALL be high in every state except IDLE; uncontended latency from strobe is 2 cycles for a write and 3 cycles for a read (read_buf valid, busy low).
REQ-022 A data-port strobe while busy=1 SHALL be dropped with no state change and SHALL set overrun; control writes are still accepted.
REQ-023 A status read SHALL clear overrun; set and clear in the same cycle SHALL leave overrun set.
REQ-024 reg_we and status_rd SHALL each be exactly one cycle wide.

Reset
REQ-025 reset_n low SHALL asynchronously force:
- state=IDLE, vaddr=0, read_buf=0, lo=0, latch=0.
- busy=0, overrun=0, reg_we=0, reg_num=0, reg_data=0.
- status_rd=0, vram_we=0, vid_valid=0.
REQ-026 Reset mid-operation SHALL abandon the pending op without a VRAM write.

Configuration
REQ-027 With VDP_STARVE_LIMIT_EN defined, a pending CPU op denied for 8 consecutive cycles SHALL take the next slot regardless of vid_req, and vid_valid SHALL be 0 for that denied video request.
REQ-028 Without VDP_STARVE_LIMIT_EN, video priority SHALL be unconditional and no starvation counter SHALL exist.

Verification
REQ-029 Control writes 0x34 then 0x87 -> one-cycle reg_we, reg_num=7, reg_data=0x34; latch=0 afterwards.
REQ-030 Control 0xFF,0x7F, then data writes 0xAA,0x55 -> VRAM[0x3FFF]=0xAA, VRAM[0x0000]=0x55, vaddr=0x0001.
REQ-031 VRAM[0x0100..0x0101]=0x11,0x22; control 0x00,0x01; wait; two data reads -> cpu_rdata 0x11 then 0x22.
REQ-032 Data write with vid_req held 5 cycles -> vram_we asserted the cycle vid_req drops, busy high throughout, vid_valid follows each vid_req.
REQ-033 Data write, then a second data write 1 cycle later -> second dropped, overrun=1; status read -> status_rd pulse, overrun=0.
REQ-034 With VDP_STARVE_LIMIT_EN, vid_req held high and a data write -> vram_we on cycle 9 after the strobe, vid_valid=0 for that slot.

Source files
------------

// File: rtl/vdp_port_ctrl.sv
// CPU data/control port front end arbitrating VDP VRAM access against video fetches.
// Optional feature: define VDP_STARVE_LIMIT_EN to bound how long video can starve a CPU op.
module vdp_port_ctrl (
  input  logic        pxclk,
  input  logic        reset_n,
  input  logic        cpu_wr_stb,
  input  logic        cpu_rd_stb,
  input  logic        cpu_port,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  input  logic        vid_req,
  input  logic [13:0] vid_addr,
  output logic        vid_valid,
  output logic [13:0] vram_addr,
  output logic        vram_we,
  output logic [7:0]  vram_wdata,
  input  logic [7:0]  vram_rdata,
  output logic        reg_we,
  output logic [2:0]  reg_num,
  output logic [7:0]  reg_data,
  input  logic [7:0]  status_in,
  output logic        status_rd,
  output logic        busy,
  output logic        overrun
);

  typedef enum logic [1:0] {IDLE, PEND_WR, PEND_RD, RD_WAIT} state_t;

  state_t      state;
  logic [13:0] vaddr;
  logic [7:0]  read_buf;
  logic [7:0]  lo;
  logic [7:0]  wr_data;
  logic        latch;
  logic        pending;
  logic        cpu_slot;
  logic        starve_go;
  logic        data_wr;
  logic        data_rd;
  logic        ctrl_wr;
  logic        ctrl_rd;
  logic        data_drop;

  assign data_wr   = cpu_wr_stb & ~cpu_port;
  assign data_rd   = cpu_rd_stb & ~cpu_port;
  assign ctrl_wr   = cpu_wr_stb & cpu_port;
  assign ctrl_rd   = cpu_rd_stb & cpu_port;
  assign busy      = (state != IDLE);
  assign pending   = (state == PEND_WR) || (state == PEND_RD);
  assign data_drop = (data_wr | data_rd) & busy;
  assign cpu_slot  = pending & (~vid_req | starve_go);

  assign cpu_rdata  = cpu_port ? status_in : read_buf;
  assign vram_wdata = wr_data;

`ifdef VDP_STARVE_LIMIT_EN
  logic [3:0] starve_cnt;

  // Counts consecutive cycles a pending CPU op lost the slot to video.
  assign starve_go = (starve_cnt == 4'd8);

  always_ff @(posedge pxclk or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt <= 4'd0;
    end else if (pending && vid_req && !starve_go) begin
      starve_cnt <= starve_cnt + 4'd1;
    end else begin
      starve_cnt <= 4'd0;
    end
  end
`else
  assign starve_go = 1'b0;
`endif

  // VRAM address/write must be combinational so video gets its data one cycle later.
  always_comb begin
    vram_addr = vid_addr;
    vram_we   = 1'b0;
    if (cpu_slot) begin
      vram_addr = vaddr;
      vram_we   = (state == PEND_WR);
    end
  end

  always_ff @(posedge pxclk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      vaddr     <= 14'd0;
      read_buf  <= 8'd0;
      lo        <= 8'd0;
      latch     <= 1'b0;
      wr_data   <= 8'd0;
      overrun   <= 1'b0;
      reg_we    <= 1'b0;
      reg_num   <= 3'd0;
      reg_data  <= 8'd0;
      status_rd <= 1'b0;
      vid_valid <= 1'b0;
    end else begin
      reg_we    <= 1'b0;
      status_rd <= ctrl_rd;
      vid_valid <= vid_req & ~starve_go;
      overrun   <= data_drop | (overrun & ~ctrl_rd);

      case (state)
        IDLE: begin
          if (data_wr) begin
            state    <= PEND_WR;
            wr_data  <= cpu_wdata;
            read_buf <= cpu_wdata;
          end else if (data_rd) begin
            state <= PEND_RD;
          end else if (ctrl_wr && latch && (cpu_wdata[7:6] == 2'b00)) begin
            state <= PEND_RD;
          end
        end
        PEND_WR: begin
          if (cpu_slot) begin
            state <= IDLE;
            vaddr <= vaddr + 14'd1;
          end
        end
        PEND_RD: begin
          if (cpu_slot) begin
            state <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          read_buf <= vram_rdata;
          vaddr    <= vaddr + 14'd1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // A dropped data strobe leaves the latch alone; control writes land even while busy.
      if ((data_wr | data_rd) && !busy) begin
        latch <= 1'b0;
      end
      if (ctrl_rd) begin
        latch <= 1'b0;
      end
      if (ctrl_wr) begin
        if (!latch) begin
          lo    <= cpu_wdata;
          latch <= 1'b1;
        end else begin
          latch <= 1'b0;
          case (cpu_wdata[7:6])
            2'b00, 2'b01: vaddr <= {cpu_wdata[5:0], lo};
            default: begin
              reg_we   <= 1'b1;
              reg_num  <= cpu_wdata[2:0];
              reg_data <= lo;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_vdp_port_ctrl.sv
// Self-checking bench for vdp_port_ctrl: register table, directed arbitration sequences,
// and randomized port traffic against an operation-level model of VRAM, address and read buffer.
module tb_vdp_port_ctrl;

  logic        pxclk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cpu_wr_stb = 1'b0;
  logic        cpu_rd_stb = 1'b0;
  logic        cpu_port = 1'b0;
  logic [7:0]  cpu_wdata = 8'd0;
  logic [7:0]  cpu_rdata;
  logic        vid_req = 1'b0;
  logic [13:0] vid_addr = 14'd0;
  logic        vid_valid;
  logic [13:0] vram_addr;
  logic        vram_we;
  logic [7:0]  vram_wdata;
  logic [7:0]  vram_rdata = 8'd0;
  logic        reg_we;
  logic [2:0]  reg_num;
  logic [7:0]  reg_data;
  logic [7:0]  status_in = 8'd0;
  logic        status_rd;
  logic        busy;
  logic        overrun;

  vdp_port_ctrl dut (
    .pxclk(pxclk), .reset_n(reset_n),
    .cpu_wr_stb(cpu_wr_stb), .cpu_rd_stb(cpu_rd_stb), .cpu_port(cpu_port),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_valid(vid_valid),
    .vram_addr(vram_addr), .vram_we(vram_we), .vram_wdata(vram_wdata), .vram_rdata(vram_rdata),
    .reg_we(reg_we), .reg_num(reg_num), .reg_data(reg_data),
    .status_in(status_in), .status_rd(status_rd),
    .busy(busy), .overrun(overrun)
  );

  always #5 pxclk = ~pxclk;

  // Single-port VRAM with one cycle of read latency.
  bit [7:0] vram [0:16383];
  always @(posedge pxclk) begin
    if (vram_we) vram[vram_addr] <= vram_wdata;
    vram_rdata <= vram[vram_addr];
  end

  bit [7:0]    ref_mem [0:16383];
  logic [13:0] m_vaddr = 14'd0;
  logic [7:0]  m_rbuf = 8'd0;
  logic        rand_vid = 1'b0;
  int          vectors = 0;
  int          miscompares = 0;

  typedef struct {
    logic [7:0] lo;
    logic [7:0] hi;
    logic       exp_we;
    logic [2:0] exp_num;
    logic [7:0] exp_data;
  } reg_vec_t;

  reg_vec_t reg_tbl [5];

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input logic wr, input logic port, input logic [7:0] data,
                                output logic [7:0] rdata);
    @(negedge pxclk);
    cpu_port   = port;
    cpu_wdata  = data;
    cpu_wr_stb = wr;
    cpu_rd_stb = ~wr;
    #1 rdata = cpu_rdata;
    @(negedge pxclk);
    cpu_wr_stb = 1'b0;
    cpu_rd_stb = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 64) begin
      @(negedge pxclk);
      if (rand_vid) vid_req = ($urandom_range(0, 2) == 0);
      n++;
    end
    if (rand_vid) vid_req = 1'b0;
    check_output({name, " idle"}, busy, 0);
  endtask

  task automatic do_data_write(input logic [7:0] d);
    logic [7:0]  r;
    logic [13:0] a;
    a = m_vaddr;
    apply_stimulus(1'b1, 1'b0, d, r);
    wait_idle("data write");
    ref_mem[a] = d;
    m_rbuf     = d;
    m_vaddr    = a + 14'd1;
    check_output("data write vram", vram[a], d);
  endtask

  task automatic do_data_read();
    logic [7:0] r;
    apply_stimulus(1'b0, 1'b0, 8'd0, r);
    check_output("data read rdata", r, m_rbuf);
    wait_idle("data read");
    m_rbuf  = ref_mem[m_vaddr];
    m_vaddr = m_vaddr + 14'd1;
    #1 check_output("data read prefetch", cpu_rdata, m_rbuf);
  endtask

  task automatic do_set_addr(input logic [13:0] a, input logic prefetch);
    logic [7:0] r;
    apply_stimulus(1'b1, 1'b1, a[7:0], r);
    apply_stimulus(1'b1, 1'b1, {1'b0, ~prefetch, a[13:8]}, r);
    m_vaddr = a;
    if (prefetch) begin
      wait_idle("addr prefetch");
      m_rbuf  = ref_mem[a];
      m_vaddr = a + 14'd1;
      cpu_port = 1'b0;
      #1 check_output("addr prefetch rbuf", cpu_rdata, m_rbuf);
    end
  endtask

  task automatic do_reg_write(input logic [7:0] lo, input logic [7:0] hi,
                              input logic exp_we, input logic [2:0] exp_num, input logic [7:0] exp_data);
    logic [7:0] r;
    apply_stimulus(1'b1, 1'b1, lo, r);
    check_output("reg lo no pulse", reg_we, 0);
    apply_stimulus(1'b1, 1'b1, hi, r);
    #1 check_output("reg_we pulse", reg_we, exp_we);
    if (exp_we) begin
      check_output("reg_num", reg_num, exp_num);
      check_output("reg_data", reg_data, exp_data);
    end
    @(negedge pxclk);
    #1 check_output("reg_we width", reg_we, 0);
  endtask

  initial begin
    logic [13:0] a;
    logic [13:0] a1;
    logic [7:0]  r;
    int          op;

    reg_tbl[0] = '{8'h34, 8'h87, 1'b1, 3'd7, 8'h34};
    reg_tbl[1] = '{8'h12, 8'hC3, 1'b1, 3'd3, 8'h12};
    reg_tbl[2] = '{8'h56, 8'h45, 1'b0, 3'd0, 8'h00};
    reg_tbl[3] = '{8'hAB, 8'h80, 1'b1, 3'd0, 8'hAB};
    reg_tbl[4] = '{8'hFE, 8'hBD, 1'b1, 3'd5, 8'hFE};

    repeat (3) @(negedge pxclk);
    check_output("reset busy", busy, 0);
    check_output("reset overrun", overrun, 0);
    check_output("reset reg_we", reg_we, 0);
    check_output("reset reg_num", reg_num, 0);
    check_output("reset reg_data", reg_data, 0);
    check_output("reset status_rd", status_rd, 0);
    check_output("reset vram_we", vram_we, 0);
    check_output("reset vid_valid", vid_valid, 0);
    check_output("reset read_buf", cpu_rdata, 0);
    reset_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      do_reg_write(reg_tbl[i].lo, reg_tbl[i].hi, reg_tbl[i].exp_we, reg_tbl[i].exp_num, reg_tbl[i].exp_data);
      if (reg_tbl[i].hi[7:6] == 2'b01) m_vaddr = {reg_tbl[i].hi[5:0], reg_tbl[i].lo};
    end

    // Address wrap at the top of VRAM.
    do_set_addr(14'h3FFF, 1'b0);
    do_data_write(8'hAA);
    do_data_write(8'h55);
    check_output("wrap vram 3fff", vram[14'h3FFF], 8'hAA);
    check_output("wrap vram 0000", vram[14'h0000], 8'h55);
    do_data_write(8'h99);
    check_output("wrap vaddr now 1", vram[14'h0001], 8'h99);

    // Write latency: busy for exactly one cycle after the strobe cycle.
    apply_stimulus(1'b1, 1'b0, 8'h66, r);
    check_output("wr latency busy c1", busy, 1);
    @(negedge pxclk);
    check_output("wr latency busy c2", busy, 0);
    ref_mem[m_vaddr] = 8'h66; m_rbuf = 8'h66; m_vaddr = m_vaddr + 14'd1;

    do_set_addr(14'h0100, 1'b0);
    do_data_write(8'h11);
    do_data_write(8'h22);
    do_set_addr(14'h0100, 1'b1);
    apply_stimulus(1'b0, 1'b0, 8'd0, r);
    check_output("read seq first", r, 8'h11);
    check_output("rd latency busy c1", busy, 1);
    @(negedge pxclk);
    check_output("rd latency busy c2", busy, 1);
    @(negedge pxclk);
    check_output("rd latency busy c3", busy, 0);
    m_rbuf = ref_mem[m_vaddr]; m_vaddr = m_vaddr + 14'd1;
    apply_stimulus(1'b0, 1'b0, 8'd0, r);
    check_output("read seq second", r, 8'h22);
    wait_idle("read seq");
    m_rbuf = ref_mem[m_vaddr]; m_vaddr = m_vaddr + 14'd1;

    // Video holds the slot for 5 cycles; the CPU write lands when it drops.
    a = m_vaddr;
    @(negedge pxclk);
    vid_addr = 14'h3FFF; vid_req = 1'b1;
    cpu_port = 1'b0; cpu_wdata = 8'h3C; cpu_wr_stb = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge pxclk);
      cpu_wr_stb = 1'b0;
      #1;
      check_output("contend busy", busy, 1);
      check_output("contend vram_we", vram_we, 0);
      check_output("contend vid_valid", vid_valid, 1);
      check_output("contend vid data", vram_rdata, 8'hAA);
    end
    @(negedge pxclk);
    vid_req = 1'b0;
    #1;
    check_output("release vram_we", vram_we, 1);
    check_output("release vram_addr", vram_addr, a);
    check_output("release vram_wdata", vram_wdata, 8'h3C);
    check_output("release busy", busy, 1);
    check_output("release vid_valid", vid_valid, 1);
    @(negedge pxclk);
    #1;
    check_output("after release busy", busy, 0);
    check_output("after release vid_valid", vid_valid, 0);
    check_output("after release vram", vram[a], 8'h3C);
    ref_mem[a] = 8'h3C; m_rbuf = 8'h3C; m_vaddr = a + 14'd1;

    // Second data write while busy is dropped and flagged.
    a = m_vaddr;
    a1 = a + 14'd1;
    @(negedge pxclk);
    cpu_port = 1'b0; cpu_wdata = 8'h5A; cpu_wr_stb = 1'b1;
    @(negedge pxclk);
    cpu_wdata = 8'hC3;
    check_output("overrun busy", busy, 1);
    @(negedge pxclk);
    cpu_wr_stb = 1'b0;
    wait_idle("overrun");
    check_output("overrun first written", vram[a], 8'h5A);
    check_output("overrun second dropped", vram[a1], ref_mem[a1]);
    check_output("overrun flag", overrun, 1);
    check_output("overrun read_buf", cpu_rdata, 8'h5A);
    ref_mem[a] = 8'h5A; m_rbuf = 8'h5A; m_vaddr = a1;
    @(negedge pxclk);
    status_in = 8'h9C; cpu_port = 1'b1; cpu_rd_stb = 1'b1;
    #1 check_output("status rdata", cpu_rdata, 8'h9C);
    @(negedge pxclk);
    cpu_rd_stb = 1'b0;
    #1;
    check_output("status_rd pulse", status_rd, 1);
    check_output("overrun cleared", overrun, 0);
    @(negedge pxclk);
    #1 check_output("status_rd width", status_rd, 0);
    cpu_port = 1'b0;

    // Continuous video request against a pending CPU write.
    a = m_vaddr;
    @(negedge pxclk);
    vid_req = 1'b1; cpu_port = 1'b0; cpu_wdata = 8'hE7; cpu_wr_stb = 1'b1;
`ifdef VDP_STARVE_LIMIT_EN
    for (int i = 1; i <= 8; i++) begin
      @(negedge pxclk);
      cpu_wr_stb = 1'b0;
      #1;
      check_output("starve denied vram_we", vram_we, 0);
      check_output("starve denied vid_valid", vid_valid, 1);
    end
    @(negedge pxclk);
    #1;
    check_output("starve forced vram_we", vram_we, 1);
    check_output("starve forced vram_addr", vram_addr, a);
    @(negedge pxclk);
    #1;
    check_output("starve slot vid_valid", vid_valid, 0);
    check_output("starve busy", busy, 0);
    vid_req = 1'b0;
`else
    for (int i = 1; i <= 12; i++) begin
      @(negedge pxclk);
      cpu_wr_stb = 1'b0;
      #1;
      check_output("priority vram_we", vram_we, 0);
      check_output("priority busy", busy, 1);
    end
    @(negedge pxclk);
    vid_req = 1'b0;
    #1 check_output("priority release vram_we", vram_we, 1);
    @(negedge pxclk);
    #1 check_output("priority busy low", busy, 0);
`endif
    check_output("starve vram", vram[a], 8'hE7);
    ref_mem[a] = 8'hE7; m_rbuf = 8'hE7; m_vaddr = a + 14'd1;

    // Randomized traffic with random video contention.
    rand_vid = 1'b1;
    for (int n = 0; n < 150; n++) begin
      op = $urandom_range(0, 9);
      if (op <= 3) begin
        do_data_write(8'($urandom));
      end else if (op <= 6) begin
        do_data_read();
      end else if (op <= 8) begin
        a = ($urandom_range(0, 1) == 1) ? 14'($urandom_range(0, 31)) : 14'(16368 + $urandom_range(0, 15));
        do_set_addr(a, 1'($urandom_range(0, 1)));
      end else begin
        r = 8'($urandom);
        a1 = 14'($urandom_range(0, 127));
        do_reg_write(r, {1'b1, a1[6:0]}, 1'b1, a1[2:0], r);
      end
    end
    rand_vid = 1'b0;
    vid_req = 1'b0;

    // Reset in the middle of a pending write must not touch VRAM.
    a = m_vaddr;
    @(negedge pxclk);
    vid_req = 1'b1; cpu_port = 1'b0; cpu_wdata = 8'h77; cpu_wr_stb = 1'b1;
    @(negedge pxclk);
    cpu_wr_stb = 1'b0;
    reset_n = 1'b0;
    #1 check_output("async reset busy", busy, 0);
    @(negedge pxclk);
    reset_n = 1'b1;
    vid_req = 1'b0;
    repeat (2) @(negedge pxclk);
    #1;
    check_output("reset abandon vram", vram[a], ref_mem[a]);
    check_output("reset abandon vram_we", vram_we, 0);
    check_output("reset abandon read_buf", cpu_rdata, 0);
    check_output("reset abandon busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
